// File: rtl/dds_pkg.sv
// Shared DDS sweep definitions: FCW limits, sweep states and the FCW clamp.
// Imported by the sweep controller and its handshake interface.
package dds_pkg;

    localparam int FCW_W = 32;

    localparam logic [FCW_W-1:0] FCW_MIN     = 32'd85899;
    localparam logic [FCW_W-1:0] FCW_MAX     = 32'd171798691;
    localparam logic [FCW_W-1:0] FCW_DEFAULT = 32'd171798691;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DWELL,
        S_STEP,
        S_DONE
    } sweep_state_t;

    function automatic logic [FCW_W-1:0] clamp_fcw(
        input logic [FCW_W-1:0] f
    );
        logic [FCW_W-1:0] r;
        r = f;
        if (f < FCW_MIN) r = FCW_MIN;
        if (f > FCW_MAX) r = FCW_MAX;
        return r;
    endfunction

endpackage

// File: rtl/dds_sweep_ctrl_if.sv
// FCW valid/ready handshake between the sweep controller and the
// phase accumulator.
interface dds_sweep_ctrl_if #(
    parameter int FCW_W = dds_pkg::FCW_W
);

    logic [FCW_W-1:0] fcw_out;
    logic             fcw_valid;
    logic             fcw_ready;

    modport master (
        output fcw_out,
        output fcw_valid,
        input  fcw_ready
    );

    modport slave (
        input  fcw_out,
        input  fcw_valid,
        output fcw_ready
    );

endinterface

// File: rtl/dds_dwell_timer.sv
// Loadable dwell down-counter; a zero load counts as one cycle and
// expire marks the last enabled cycle of the hold.
module dds_dwell_timer #(
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               en,
    input  logic [DWELL_W-1:0] dwell,
    output logic               expire
);

    logic [DWELL_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= (dwell == '0) ? DWELL_W'(1) : dwell;
        end else if (en && cnt != '0) begin
            cnt <= cnt - DWELL_W'(1);
        end
    end

    assign expire = en && (cnt == DWELL_W'(1));

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Linear DDS frequency sweep scheduler feeding the phase accumulator.
// Define DDS_SWEEP_TRIANGLE_EN to enable up/down (triangle) sweeps.
module dds_sweep_ctrl #(
    parameter int FCW_W   = 32,
    parameter int DWELL_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 cont,
    input  logic                 tri_mode,
    input  logic [FCW_W-1:0]     f_start,
    input  logic [FCW_W-1:0]     f_stop,
    input  logic [FCW_W-1:0]     f_delta,
    input  logic [DWELL_W-1:0]   dwell,
    dds_sweep_ctrl_if.master     fcw,
    output logic                 busy,
    output logic                 done
);

    import dds_pkg::*;

    sweep_state_t state, nxt_state;

    logic               cont_q, tri_q, dir_q, leg_q;
    logic [FCW_W-1:0]   start_q, target_q, delta_q;
    logic [DWELL_W-1:0] dwell_q;
    logic [FCW_W-1:0]   cap_start, cap_stop, step_val;
    logic [FCW_W:0]     sum, dif;
    logic               accept, at_end, turn, expire, tmr_load;

    assign cap_start = clamp_fcw(f_start);
    assign cap_stop  = clamp_fcw(f_stop);
    assign accept    = fcw.fcw_valid && fcw.fcw_ready;
    assign at_end    = (fcw.fcw_out == target_q) || (delta_q == '0);
    assign tmr_load  = (state == S_LOAD) && accept && !stop;

`ifdef DDS_SWEEP_TRIANGLE_EN
    // Turn around at the end point instead of restarting from start.
    assign turn = tri_q && expire && (delta_q != '0)
               && (fcw.fcw_out == target_q) && (start_q != target_q)
               && (cont_q || !leg_q);
`else
    logic unused_tri;
    assign unused_tri = tri_q ^ leg_q;
    assign turn = 1'b0;
`endif

    dds_dwell_timer #(
        .DWELL_W (DWELL_W)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (tmr_load),
        .en     (state == S_DWELL),
        .dwell  (dwell_q),
        .expire (expire)
    );

    // Extra bit catches wrap past either end of the FCW range.
    assign sum = {1'b0, fcw.fcw_out} + {1'b0, delta_q};
    assign dif = {1'b0, fcw.fcw_out} - {1'b0, delta_q};

    always_comb begin
        step_val = target_q;
        if (dir_q) begin
            if (!sum[FCW_W] && sum[FCW_W-1:0] < target_q)
                step_val = sum[FCW_W-1:0];
        end else begin
            if (!dif[FCW_W] && dif[FCW_W-1:0] > target_q)
                step_val = dif[FCW_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= nxt_state;
    end

    always_comb begin
        nxt_state = state;
        unique case (state)
            S_IDLE:  if (start && !stop) nxt_state = S_LOAD;
            S_LOAD: begin
                if (stop)        nxt_state = S_IDLE;
                else if (accept) nxt_state = S_DWELL;
            end
            S_DWELL: begin
                if (stop)
                    nxt_state = S_IDLE;
                else if (expire)
                    nxt_state = (at_end && !turn) ? S_DONE : S_STEP;
            end
            S_STEP:  nxt_state = stop ? S_IDLE : S_LOAD;
            S_DONE:  nxt_state = (!stop && cont_q) ? S_LOAD : S_IDLE;
            default: nxt_state = S_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state)
            S_LOAD, S_DWELL, S_STEP: busy = 1'b1;
            S_DONE: begin
                busy = cont_q;
                done = !cont_q && !stop;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fcw.fcw_out   <= FCW_DEFAULT;
            fcw.fcw_valid <= 1'b0;
            cont_q        <= 1'b0;
            tri_q         <= 1'b0;
            dir_q         <= 1'b1;
            leg_q         <= 1'b0;
            start_q       <= '0;
            target_q      <= '0;
            delta_q       <= '0;
            dwell_q       <= '0;
        end else begin
            unique case (state)
                S_IDLE: if (start && !stop) begin
                    cont_q        <= cont;
                    tri_q         <= tri_mode;
                    start_q       <= cap_start;
                    target_q      <= cap_stop;
                    delta_q       <= f_delta;
                    dwell_q       <= dwell;
                    dir_q         <= (cap_stop >= cap_start);
                    leg_q         <= 1'b0;
                    fcw.fcw_out   <= cap_start;
                    fcw.fcw_valid <= 1'b1;
                end
                S_LOAD: if (stop || fcw.fcw_ready) fcw.fcw_valid <= 1'b0;
                S_DWELL: if (!stop && turn) begin
                    start_q  <= target_q;
                    target_q <= start_q;
                    dir_q    <= !dir_q;
                    leg_q    <= 1'b1;
                end
                S_STEP: if (!stop) begin
                    fcw.fcw_out   <= step_val;
                    fcw.fcw_valid <= 1'b1;
                end
                S_DONE: if (!stop && cont_q) begin
                    fcw.fcw_out   <= start_q;
                    fcw.fcw_valid <= 1'b1;
                    leg_q         <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Self-checking bench for dds_sweep_ctrl: point-list model, handshake
// and dwell-timing monitor, directed sweep/abort/reset cases.
`timescale 1ns/1ps
module tb_dds_sweep_ctrl;

`ifdef DDS_SWEEP_TRIANGLE_EN
    localparam bit TRI = 1'b1;
`else
    localparam bit TRI = 1'b0;
`endif

    logic        clk = 0, reset = 0, start = 0, stop = 0;
    logic        cont = 0, tri_mode = 0;
    logic [31:0] f_start = 0, f_stop = 0, f_delta = 0;
    logic [15:0] dwell = 0;
    logic        busy, done;

    dds_sweep_ctrl_if #(.FCW_W(32)) fcw_if();

    dds_sweep_ctrl #(.FCW_W(32), .DWELL_W(16)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .cont(cont), .tri_mode(tri_mode), .f_start(f_start),
        .f_stop(f_stop), .f_delta(f_delta), .dwell(dwell),
        .fcw(fcw_if), .busy(busy), .done(done)
    );

    always #10 clk = ~clk;

    int n_pass = 0, n_total = 0;
    int cyc = 0, acc_cyc = 0, cur_dwell = 1, done_cnt = 0;
    bit have_acc = 0, exp_done = 0;
    logic [31:0] exp_q[$];
    logic        prev_valid = 0, prev_ready = 0;
    logic [31:0] prev_fcw = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act,
                         input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic longint clampm(input longint f);
        if (f < 85899) return 85899;
        if (f > 171798691) return 171798691;
        return f;
    endfunction

    // Points of one leg from a to b: steps of d, last point exactly b.
    task automatic push_leg(input longint a, input longint b,
                            input longint d, input bit skip_first);
        longint v;
        v = a;
        if (!skip_first) exp_q.push_back(32'(v));
        while (v != b) begin
            if (b > v) v = (b - v <= d) ? b : v + d;
            else       v = (v - b <= d) ? b : v - d;
            exp_q.push_back(32'(v));
        end
    endtask

    task automatic build(input longint fs, input longint fe,
                         input longint fd, input bit tri_on,
                         input int legs);
        longint s, t;
        s = clampm(fs);
        t = clampm(fe);
        exp_q.delete();
        for (int i = 0; i < legs; i++) begin
            if (fd == 0 || s == t)       exp_q.push_back(32'(s));
            else if (tri_on && i % 2 == 1) push_leg(t, s, fd, 1'b1);
            else                          push_leg(s, t, fd, tri_on && i > 0);
        end
    endtask

    always @(negedge clk) begin
        if (fcw_if.fcw_valid && prev_valid && !prev_ready)
            check("hold_stable", fcw_if.fcw_out, prev_fcw);
        if (fcw_if.fcw_valid && !prev_valid && have_acc)
            check("dwell_gap", cyc - acc_cyc, cur_dwell + 2);
        if (fcw_if.fcw_valid)
            check("busy_with_valid", busy, 1);
        if (fcw_if.fcw_valid && fcw_if.fcw_ready) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL extra_point: got %0d expected none",
                         fcw_if.fcw_out);
            end else begin
                check("point", fcw_if.fcw_out, exp_q.pop_front());
            end
            acc_cyc  = cyc;
            have_acc = 1;
        end
        if (done) begin
            check("done_gap", cyc - acc_cyc, cur_dwell + 1);
            check("done_expected", exp_done, 1);
            check("done_all_points", exp_q.size(), 0);
            done_cnt++;
        end
        prev_valid = fcw_if.fcw_valid;
        prev_ready = fcw_if.fcw_ready;
        prev_fcw   = fcw_if.fcw_out;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [31:0] fs, input logic [31:0] fe,
                      input logic [31:0] fd, input logic [15:0] dw,
                      input bit c, input bit t);
        f_start = fs; f_stop = fe; f_delta = fd; dwell = dw;
        cont = c; tri_mode = t;
        cur_dwell = (dw == 0) ? 1 : int'(dw);
        have_acc = 0;
        exp_done = !c;
        start = 1;
        step();
        start = 0;
        f_start = 32'hDEAD_BEEF; f_stop = 0; f_delta = 1; dwell = 16'd7;
        check("start_valid", fcw_if.fcw_valid, 1);
        check("start_busy", busy, 1);
    endtask

    task automatic wait_done(input int max, input string name);
        int d0, i;
        d0 = done_cnt;
        i = 0;
        while (done_cnt == d0 && i < max) begin
            @(posedge clk);
            i++;
        end
        check({name, "_done_seen"}, done_cnt - d0, 1);
        #1;
    endtask

    task automatic wait_empty(input int max, input string name);
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < max) begin
            @(posedge clk);
            i++;
        end
        check({name, "_points_left"}, exp_q.size(), 0);
        #1;
    endtask

    task automatic stop_cont(input string name);
        int d0;
        d0 = done_cnt;
        stop = 1;
        step();
        stop = 0;
        check({name, "_stop_busy"}, busy, 0);
        check({name, "_stop_valid"}, fcw_if.fcw_valid, 0);
        repeat (6) step();
        check({name, "_no_done"}, done_cnt - d0, 0);
    endtask

    initial begin
        int d0;
        logic [31:0] last;
        fcw_if.fcw_ready = 1;
        repeat (3) step();
        reset = 1;
        repeat (2) step();
        check("rst_fcw", fcw_if.fcw_out, 171798691);
        check("rst_valid", fcw_if.fcw_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);

        build(858993, 4294967, 858993, 1'b0, 1);
        check("model_up_n", exp_q.size(), 6);
        check("model_up_p4", exp_q[4], 4294965);
        check("model_up_last", exp_q[5], 4294967);
        go(858993, 4294967, 858993, 3, 0, 0);
        wait_done(200, "up");
        check("up_final", fcw_if.fcw_out, 4294967);
        check("up_busy", busy, 0);
        step();
        check("up_done_1cyc", done, 0);

        build(200000000, 0, 50000000, 1'b0, 1);
        check("model_dn_first", exp_q[0], 171798691);
        check("model_dn_last", exp_q[exp_q.size()-1], 85899);
        go(200000000, 0, 50000000, 0, 0, 0);
        wait_done(200, "down");
        check("down_final", fcw_if.fcw_out, 85899);

        build(1000000, 3000000, 1000000, 1'b0, 1);
        fcw_if.fcw_ready = 0;
        go(1000000, 3000000, 1000000, 2, 0, 0);
        repeat (3) step();
        start = 1; f_start = 5000000;
        step();
        start = 0;
        repeat (6) step();
        check("stall_valid", fcw_if.fcw_valid, 1);
        check("stall_fcw", fcw_if.fcw_out, 1000000);
        fcw_if.fcw_ready = 1;
        wait_done(200, "stall");
        check("stall_final", fcw_if.fcw_out, 3000000);

        build(1000000, 5000000, 0, 1'b0, 1);
        go(1000000, 5000000, 0, 2, 0, 0);
        wait_done(100, "delta0");
        check("delta0_final", fcw_if.fcw_out, 1000000);

        build(2000000, 2000000, 500000, 1'b0, 1);
        go(2000000, 2000000, 500000, 1, 0, 0);
        wait_done(100, "single");
        check("single_final", fcw_if.fcw_out, 2000000);

        build(858993, 4294967, 858993, 1'b0, 1);
        go(858993, 4294967, 858993, 3, 0, 0);
        step();
        start = 1; f_start = 5000000;
        step();
        start = 0;
        stop = 1;
        exp_q.delete();
        exp_done = 0;
        d0 = done_cnt;
        step();
        stop = 0;
        check("abort_valid", fcw_if.fcw_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_fcw", fcw_if.fcw_out, 858993);
        repeat (10) step();
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_idle_valid", fcw_if.fcw_valid, 0);

        f_start = 1000000; f_stop = 2000000; f_delta = 1000;
        start = 1; stop = 1;
        step();
        start = 0; stop = 0;
        check("startstop_valid", fcw_if.fcw_valid, 0);
        check("startstop_busy", busy, 0);

        build(1000000, 3000000, 1000000, 1'b0, 1);
        fcw_if.fcw_ready = 0;
        go(1000000, 3000000, 1000000, 2, 0, 0);
        step();
        step();
        exp_q.delete();
        exp_done = 0;
        reset = 0;
        #1;
        check("rstmid_valid", fcw_if.fcw_valid, 0);
        check("rstmid_busy", busy, 0);
        check("rstmid_fcw", fcw_if.fcw_out, 171798691);
        check("rstmid_done", done, 0);
        step();
        reset = 1;
        fcw_if.fcw_ready = 1;
        step();
        check("rstmid_after_valid", fcw_if.fcw_valid, 0);

        build(85899, 171879, 85980, 1'b0, 3);
        check("model_saw2_p2", exp_q[2], 85899);
        go(85899, 171879, 85980, 2, 1, 0);
        wait_empty(300, "saw2");
        stop_cont("saw2");

        build(85899, 257859, 85980, TRI, TRI ? 4 : 3);
        check("model_cont3_p3", exp_q[3], TRI ? 171879 : 85899);
        go(85899, 257859, 85980, 1, 1, 1);
        wait_empty(300, "cont3");
        stop_cont("cont3");

        build(85899, 257859, 85980, TRI, TRI ? 2 : 1);
        last = exp_q[exp_q.size()-1];
        go(85899, 257859, 85980, 1, 0, 1);
        wait_done(200, "tri1");
        check("tri1_final", fcw_if.fcw_out, last);
        check("tri1_final_lit", fcw_if.fcw_out, TRI ? 85899 : 257859);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
